hazard_tnew_pipe: RTL
=====================

# hazard_tnew_pipe

Producer side of the ID-stage stall/forward protocol. It decodes the instruction leaving IF/ID into a (write-address, Tnew) pair, then carries that pair through the ID/EX, EX/MEM and MEM/WB stages. Tnew counts down toward zero as the pair advances, and stall bubbles are inserted when requested. It also tracks the HI/LO multiply/divide unit's busy window and raises a stall for instructions that depend on HI/LO. It sits beside the pipeline registers and feeds the `*_WAddr` and `*_Tnew` inputs of the ID-stage hazard controller.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  clock. One clock domain. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `IF_ID_Instr`  in  32  instruction currently in the ID stage.
- `ID_WAddr`  in  5  destination register decoded in ID; 0 means no write.
- `Install`  in  1  final stall signal (hazard stall OR `MD_Stall`, combined outside this block). When high, ID/EX receives a bubble.
- `ID_EX_WAddr`, `EX_MEM_WAddr`, `MEM_WB_WAddr`  out  5 each  destination carried by each stage.
- `ID_EX_Tnew`, `EX_MEM_Tnew`, `MEM_WB_Tnew`  out  4 each  cycles remaining until that stage's result can be forwarded.
- `MD_Busy`  out  1  the mult/div unit is computing.
- `MD_Stall`  out  1  combinational; the ID instruction must wait for the mult/div unit.

## Operation
- Tnew decode from `IF_ID_Instr`, as the value entering ID/EX:
  - LB/LBU/LH/LHU/LW: 2.
  - R-type ALU, I-type ALU, LUI, MFHI, MFLO: 1.
  - JAL, JALR: 0.
  - If `ID_WAddr`==0, Tnew is forced to 0.
- ID/EX update every cycle:
  - `Install`=0: load (`ID_WAddr`, decoded Tnew).
  - `Install`=1: load bubble (0, 0).
- EX/MEM and MEM/WB advance every cycle regardless of `Install`:
  - `EX_MEM_Tnew` <= sat0(`ID_EX_Tnew` - 1).
  - `MEM_WB_Tnew` <= sat0(`EX_MEM_Tnew` - 1).
  - Addresses copy unchanged from the previous stage.
- sat0 means 4-bit subtraction clamped at 0; no wrap from 0 to 15.
- Invariant: a stage with WAddr==0 always holds Tnew==0.
- MD instruction classes:
  - MD-start: MULT, MULTU, DIV, DIVU.
  - MD-use: MD-start, MFHI, MFLO, MTHI, MTLO.
- MD counter (4-bit):
  - When an MD-start instruction loads into ID/EX (`Install`=0), load `MULT_CYCLES` or `DIV_CYCLES`.
  - Otherwise decrement when nonzero, and hold at 0.
- `MD_Busy` = (counter != 0).
- `MD_Stall` = ID instruction is MD-use AND `MD_Busy`.
- A new load cannot collide with a nonzero count: an MD-start in ID while busy is itself stalled.

## Timing
- Reset (synchronous, any cycle, including mid-countdown): all WAddr, all Tnew and the MD counter are cleared to 0 at the edge. After that edge `MD_Busy`=0 and `MD_Stall`=0.
- Latency: a pair decoded in ID at cycle t appears in ID/EX at t+1, in EX/MEM at t+2 and in MEM/WB at t+3.
- `Install` takes effect at the next edge only. EX/MEM and MEM/WB are never frozen by it.
- MD busy window: MULT in ID at cycle t (unstalled) gives `MD_Busy`=1 for cycles t+1 through t+5 and 0 at t+6. An MFLO in ID is stalled through t+5 and proceeds at t+6.
- Simultaneous MD-start entry and a nonzero count cannot occur (see Operation). Reset wins over all other updates.

## Structure
- Opcode and funct constants come from `defines.v`.
- Add to `defines.v`:
  - `TNEW_LOAD`=2, `TNEW_ALU`=1, `TNEW_LINK`=0.
  - Default mult/div cycle counts, for the parameters.
- One sub-module, `md_busy_counter`: load/decrement counter that outputs `MD_Busy`.
- Tnew decode and the three stage registers stay in the top block.

## Test plan
- LW $t0 in ID, `Install`=0 → ID/EX shows (8, 2), then EX/MEM (8, 1), then MEM/WB (8, 0).
- ADDU $t1 in ID with `Install`=1 → ID/EX=(0, 0) next cycle; the older EX/MEM and MEM/WB contents still advance.
- JAL → ID/EX shows (31, 0); EX/MEM shows (31, 0), with no underflow to 15.
- ORI $zero → `ID_WAddr`=0 → every stage shows Tnew 0.
- DIV, then MFHI held in ID → `MD_Stall`=1 for exactly 10 cycles and `MD_Busy` drops on the 11th.
- `reset` pulsed at count 3 of a MULT → counter is 0 next cycle, `MD_Stall` is 0, and all outputs are 0.

Source files
------------

// File: rtl/hazard_tnew_pipe_pkg.sv
// hazard_tnew_pipe_pkg
// Shared constants and helpers for the Tnew producer pipeline:
//   - MIPS opcode / funct field values used by the Tnew and mult/div decode
//   - Tnew values for each instruction class
//   - default mult/div busy cycle counts
//   - helper functions: saturating decrement and mult/div instruction classes
package hazard_tnew_pipe_pkg;

  // Tnew seen by the instruction as it enters ID/EX
  localparam logic [3:0] TNEW_LOAD = 4'd2;
  localparam logic [3:0] TNEW_ALU  = 4'd1;
  localparam logic [3:0] TNEW_LINK = 4'd0;

  // Default busy windows of the HI/LO unit
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // 4-bit decrement that sticks at zero instead of wrapping to 15
  function automatic logic [3:0] sat0_dec(input logic [3:0] value);
    logic [3:0] result;
    if (value == 4'd0) begin
      result = 4'd0;
    end else begin
      result = value - 4'd1;
    end
    return result;
  endfunction

  // MULT/MULTU/DIV/DIVU: instructions that start the HI/LO unit
  function automatic logic is_md_start(input logic [5:0] opcode, input logic [5:0] funct);
    logic result;
    result = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: result = 1'b1;
        default:                            result = 1'b0;
      endcase
    end else begin
      result = 1'b0;
    end
    return result;
  endfunction

  // Any instruction touching HI/LO must wait while the unit is busy
  function automatic logic is_md_use(input logic [5:0] opcode, input logic [5:0] funct);
    logic result;
    result = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
        FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: result = 1'b1;
        default:                            result = 1'b0;
      endcase
    end else begin
      result = 1'b0;
    end
    return result;
  endfunction

  // DIV/DIVU select the longer busy window
  function automatic logic is_div(input logic [5:0] funct);
    logic result;
    case (funct)
      FN_DIV, FN_DIVU: result = 1'b1;
      default:         result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/hazard_tnew_pipe_md_busy_counter.sv
// md_busy_counter
// Load/decrement counter modelling the busy window of the HI/LO unit.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load            start a new operation this cycle
//   load_value[3:0] busy cycles of the new operation
//   busy            registered: counter is nonzero
module md_busy_counter
  import hazard_tnew_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       busy
);

  logic [3:0] count_r;
  logic [3:0] count_next_s;
  logic       busy_r;

  // Next count: load a new window, otherwise run down to zero and stay there
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = load_value;
    end else begin
      count_next_s = sat0_dec(count_r);
    end
  end

  // Counter and busy flag; busy is derived from the next count so it stays registered
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      busy_r  <= (count_next_s != 4'd0);
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe
// Producer side of the ID-stage stall/forward protocol. Decodes the ID
// instruction into a (write address, Tnew) pair and carries it through
// ID/EX, EX/MEM and MEM/WB, counting Tnew down to zero. Also tracks the
// HI/LO unit busy window and flags ID instructions that must wait for it.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   IF_ID_Instr[31:0]                 instruction in ID
//   ID_WAddr[4:0]                     destination decoded in ID (0 = none)
//   Install                           final stall: bubble into ID/EX
//   ID_EX/EX_MEM/MEM_WB_WAddr[4:0]    destination per stage
//   ID_EX/EX_MEM/MEM_WB_Tnew[3:0]     cycles until forwardable per stage
//   MD_Busy                           HI/LO unit computing
//   MD_Stall                          combinational: ID instr waits for HI/LO
module hazard_tnew_pipe
  import hazard_tnew_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID_Instr,
  input  logic [4:0]  ID_WAddr,
  input  logic        Install,
  output logic [4:0]  ID_EX_WAddr,
  output logic [4:0]  EX_MEM_WAddr,
  output logic [4:0]  MEM_WB_WAddr,
  output logic [3:0]  ID_EX_Tnew,
  output logic [3:0]  EX_MEM_Tnew,
  output logic [3:0]  MEM_WB_Tnew,
  output logic        MD_Busy,
  output logic        MD_Stall
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_instr_s;
  logic [3:0] tnew_dec_s;
  logic [3:0] tnew_id_s;
  logic       md_load_s;
  logic [3:0] md_load_value_s;
  logic       md_busy_s;

  logic [4:0] id_ex_waddr_r;
  logic [4:0] ex_mem_waddr_r;
  logic [4:0] mem_wb_waddr_r;
  logic [3:0] id_ex_tnew_r;
  logic [3:0] ex_mem_tnew_r;
  logic [3:0] mem_wb_tnew_r;

  assign opcode_s       = IF_ID_Instr[31:26];
  assign funct_s        = IF_ID_Instr[5:0];
  assign unused_instr_s = ^IF_ID_Instr[25:6];

  // Tnew of the ID instruction by class; anything unlisted produces nothing forwardable later
  always_comb begin
    tnew_dec_s = TNEW_LINK;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO:
            tnew_dec_s = TNEW_ALU;
          FN_JALR:
            tnew_dec_s = TNEW_LINK;
          default:
            tnew_dec_s = TNEW_LINK;
        endcase
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:
        tnew_dec_s = TNEW_LOAD;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        tnew_dec_s = TNEW_ALU;
      OP_JAL:
        tnew_dec_s = TNEW_LINK;
      default:
        tnew_dec_s = TNEW_LINK;
    endcase
  end

  // A pair with no destination must never look like a pending result
  always_comb begin
    tnew_id_s = 4'd0;
    if (ID_WAddr == 5'd0) begin
      tnew_id_s = 4'd0;
    end else begin
      tnew_id_s = tnew_dec_s;
    end
  end

  // Stage registers: ID/EX takes a bubble on Install; later stages always advance
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_waddr_r  <= 5'd0;
      id_ex_tnew_r   <= 4'd0;
      ex_mem_waddr_r <= 5'd0;
      ex_mem_tnew_r  <= 4'd0;
      mem_wb_waddr_r <= 5'd0;
      mem_wb_tnew_r  <= 4'd0;
    end else begin
      if (Install) begin
        id_ex_waddr_r <= 5'd0;
        id_ex_tnew_r  <= 4'd0;
      end else begin
        id_ex_waddr_r <= ID_WAddr;
        id_ex_tnew_r  <= tnew_id_s;
      end
      ex_mem_waddr_r <= id_ex_waddr_r;
      ex_mem_tnew_r  <= sat0_dec(id_ex_tnew_r);
      mem_wb_waddr_r <= ex_mem_waddr_r;
      mem_wb_tnew_r  <= sat0_dec(ex_mem_tnew_r);
    end
  end

  // An MD-start can only load when it actually leaves ID; a busy unit keeps it stalled
  assign md_load_s       = is_md_start(opcode_s, funct_s) & ~Install;
  assign md_load_value_s = is_div(funct_s) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  md_busy_counter u_md_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (md_load_s),
    .load_value (md_load_value_s),
    .busy       (md_busy_s)
  );

  assign MD_Busy  = md_busy_s;
  assign MD_Stall = is_md_use(opcode_s, funct_s) & md_busy_s;

  assign ID_EX_WAddr  = id_ex_waddr_r;
  assign EX_MEM_WAddr = ex_mem_waddr_r;
  assign MEM_WB_WAddr = mem_wb_waddr_r;
  assign ID_EX_Tnew   = id_ex_tnew_r;
  assign EX_MEM_Tnew  = ex_mem_tnew_r;
  assign MEM_WB_Tnew  = mem_wb_tnew_r;

endmodule
